// File: rtl/sdmac_fifo_pack.sv
// DMA FIFO between the 8-bit SCSI byte side and the wide memory side.
// Packs bytes into big-endian words (DIR=1) or unpacks words into bytes (DIR=0).
module sdmac_fifo_pack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned PW    = $clog2(DEPTH),
  parameter int unsigned BW    = $clog2(LANES)
) (
  input  logic               CLK,
  input  logic               RST_FIFO_,
  input  logic               DIR,
  input  logic [8*LANES-1:0] ID,
  input  logic               WORD_WR,
  input  logic               WORD_RD,
  output logic [8*LANES-1:0] OD,
  input  logic [7:0]         SD_IN,
  input  logic               BYTE_WR,
  input  logic               BYTE_RD,
  output logic [7:0]         SD_OUT,
  input  logic               BP_LOAD,
  input  logic [BW-1:0]      BP_VAL,
  input  logic               FLUSH,
  input  logic               ERR_CLR,
  output logic               FIFOFULL,
  output logic               FIFOEMPTY,
  output logic [PW:0]        COUNT,
  output logic [BW-1:0]      BP,
  output logic               BOEQ0,
  output logic               BOEQLAST,
  output logic               PARTIAL,
  output logic               ERR
);
  localparam int unsigned W = 8 * LANES;
  localparam logic [BW-1:0] BpLast  = BW'(LANES - 1);
  localparam logic [PW:0]   CntFull = (PW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  logic [BW-1:0] bp_q, bp_d;
  logic [W-1:0]  asm_q, asm_d, asm_byte, push_data;
  logic          asm_valid_q, asm_valid_d;
  logic          err_q, err_d;
  logic          push_req, pop_req, push_ok, pop_ok, err_set;
  logic          full, empty;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);

  always_comb begin
    bp_d        = bp_q;
    asm_d       = asm_q;
    asm_valid_d = asm_valid_q;
    asm_byte    = asm_q;
    asm_byte[bp_q*8 +: 8] = SD_IN;
    push_req    = 1'b0;
    pop_req     = 1'b0;
    push_data   = ID;
    err_set     = 1'b0;

    // BP_LOAD overrides every byte-side strobe in the same cycle.
    if (BP_LOAD) begin
      bp_d        = BP_VAL;
      asm_d       = '0;
      asm_valid_d = 1'b0;
    end else if (DIR) begin
      if (BYTE_WR) begin
        if (bp_q == '0) begin
          push_req    = 1'b1;
          push_data   = asm_byte;
          bp_d        = BpLast;
          asm_d       = '0;
          asm_valid_d = 1'b0;
        end else begin
          asm_d       = asm_byte;
          bp_d        = bp_q - BW'(1);
          asm_valid_d = 1'b1;
        end
      end else if (FLUSH && asm_valid_q) begin
        push_req    = 1'b1;
        push_data   = asm_q;
        bp_d        = BpLast;
        asm_d       = '0;
        asm_valid_d = 1'b0;
      end
    end else if (BYTE_RD) begin
      if (empty) begin
        err_set = 1'b1;
      end else if (bp_q == '0) begin
        pop_req = 1'b1;
        bp_d    = BpLast;
      end else begin
        bp_d = bp_q - BW'(1);
      end
    end

    if (DIR && WORD_RD)   pop_req  = 1'b1;
    if (!DIR && WORD_WR)  push_req = 1'b1;

    // A pop frees a slot for a same-cycle push when full; no bypass when empty.
    pop_ok  = pop_req && !empty;
    push_ok = push_req && (!full || pop_ok);
    if (pop_req && !pop_ok)   err_set = 1'b1;
    if (push_req && !push_ok) err_set = 1'b1;

    wptr_d  = push_ok ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop_ok  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + (PW + 1)'(1);
    else if (!push_ok && pop_ok) count_d = count_q - (PW + 1)'(1);

    if (err_set)      err_d = 1'b1;
    else if (ERR_CLR) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge CLK or negedge RST_FIFO_) begin
    if (!RST_FIFO_) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      bp_q        <= BpLast;
      asm_q       <= '0;
      asm_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (push_ok) mem_q[wptr_q] <= push_data;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      bp_q        <= bp_d;
      asm_q       <= asm_d;
      asm_valid_q <= asm_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    OD        = mem_q[rptr_q];
    SD_OUT    = OD[bp_q*8 +: 8];
    FIFOFULL  = full;
    FIFOEMPTY = empty;
    COUNT     = count_q;
    BP        = bp_q;
    BOEQ0     = (bp_q == '0);
    BOEQLAST  = (bp_q == BpLast);
    PARTIAL   = DIR && asm_valid_q;
    ERR       = err_q;
  end
endmodule

// File: tb/tb_sdmac_fifo_pack.sv
// Directed-vector bench for sdmac_fifo_pack (DEPTH=8, LANES=4).
module tb_sdmac_fifo_pack;
  logic        CLK = 1'b0;
  logic        RST_FIFO_ = 1'b0;
  logic        DIR = 1'b1;
  logic [31:0] ID = '0;
  logic        WORD_WR = 1'b0, WORD_RD = 1'b0;
  logic [31:0] OD;
  logic [7:0]  SD_IN = '0;
  logic        BYTE_WR = 1'b0, BYTE_RD = 1'b0;
  logic [7:0]  SD_OUT;
  logic        BP_LOAD = 1'b0;
  logic [1:0]  BP_VAL = '0;
  logic        FLUSH = 1'b0, ERR_CLR = 1'b0;
  logic        FIFOFULL, FIFOEMPTY, BOEQ0, BOEQLAST, PARTIAL, ERR;
  logic [3:0]  COUNT;
  logic [1:0]  BP;

  int n_cmp = 0;
  int n_bad = 0;

  sdmac_fifo_pack #(.DEPTH(8), .LANES(4)) dut (
    .CLK(CLK), .RST_FIFO_(RST_FIFO_), .DIR(DIR), .ID(ID), .WORD_WR(WORD_WR),
    .WORD_RD(WORD_RD), .OD(OD), .SD_IN(SD_IN), .BYTE_WR(BYTE_WR), .BYTE_RD(BYTE_RD),
    .SD_OUT(SD_OUT), .BP_LOAD(BP_LOAD), .BP_VAL(BP_VAL), .FLUSH(FLUSH),
    .ERR_CLR(ERR_CLR), .FIFOFULL(FIFOFULL), .FIFOEMPTY(FIFOEMPTY), .COUNT(COUNT),
    .BP(BP), .BOEQ0(BOEQ0), .BOEQLAST(BOEQLAST), .PARTIAL(PARTIAL), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked there too.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic byte_wr(input logic [7:0] b);
    SD_IN = b; BYTE_WR = 1'b1; cyc(); BYTE_WR = 1'b0;
  endtask

  task automatic byte_rd();
    BYTE_RD = 1'b1; cyc(); BYTE_RD = 1'b0;
  endtask

  task automatic word_wr(input logic [31:0] w);
    ID = w; WORD_WR = 1'b1; cyc(); WORD_WR = 1'b0;
  endtask

  task automatic word_rd();
    WORD_RD = 1'b1; cyc(); WORD_RD = 1'b0;
  endtask

  task automatic err_clr();
    ERR_CLR = 1'b1; cyc(); ERR_CLR = 1'b0;
  endtask

  logic [31:0] exp_w;

  initial begin
    #12 RST_FIFO_ = 1'b1;
    cyc();
    check_eq("rst_count", COUNT, 0);
    check_eq("rst_empty", FIFOEMPTY, 1);
    check_eq("rst_full", FIFOFULL, 0);
    check_eq("rst_bp", BP, 3);
    check_eq("rst_boeqlast", BOEQLAST, 1);
    check_eq("rst_od", OD, 0);
    check_eq("rst_sdout", SD_OUT, 0);
    check_eq("rst_err", ERR, 0);
    check_eq("rst_partial", PARTIAL, 0);

    // 1: pack two words, pop them back
    byte_wr(8'h11);
    check_eq("t1_bp_after1", BP, 2);
    check_eq("t1_partial", PARTIAL, 1);
    byte_wr(8'h22); byte_wr(8'h33); byte_wr(8'h44);
    check_eq("t1_count1", COUNT, 1);
    check_eq("t1_od1", OD, 32'h11223344);
    check_eq("t1_bp_wrap", BP, 3);
    byte_wr(8'h55); byte_wr(8'h66); byte_wr(8'h77);
    check_eq("t1_boeq0", BOEQ0, 1);
    byte_wr(8'h88);
    check_eq("t1_count2", COUNT, 2);
    word_rd();
    check_eq("t1_od2", OD, 32'h55667788);
    word_rd();
    check_eq("t1_empty", FIFOEMPTY, 1);
    check_eq("t1_err", ERR, 0);

    // 2: fill, overflow, clear
    for (int i = 0; i < 32; i++) byte_wr(8'(i + 1));
    check_eq("t2_full", FIFOFULL, 1);
    check_eq("t2_count", COUNT, 8);
    check_eq("t2_err0", ERR, 0);
    for (int i = 0; i < 4; i++) byte_wr(8'hE0 + 8'(i));
    check_eq("t2_err1", ERR, 1);
    check_eq("t2_count_ovf", COUNT, 8);
    check_eq("t2_od_head", OD, 32'h01020304);
    check_eq("t2_bp_ovf", BP, 3);
    err_clr();
    check_eq("t2_errclr", ERR, 0);
    for (int k = 0; k < 8; k++) begin
      exp_w = {8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)};
      check_eq("t2_drain_od", OD, exp_w);
      word_rd();
    end
    check_eq("t2_drained", FIFOEMPTY, 1);
    word_rd();
    check_eq("t2_underrun", ERR, 1);
    err_clr();

    // 3: byte pointer load and flush
    BP_LOAD = 1'b1; BP_VAL = 2'd1; cyc(); BP_LOAD = 1'b0;
    check_eq("t3_bpload", BP, 1);
    byte_wr(8'hAA); byte_wr(8'hBB);
    check_eq("t3_count1", COUNT, 1);
    check_eq("t3_od1", OD, 32'h0000AABB);
    byte_wr(8'hCC); byte_wr(8'hDD); byte_wr(8'hEE);
    check_eq("t3_partial1", PARTIAL, 1);
    FLUSH = 1'b1; cyc(); FLUSH = 1'b0;
    check_eq("t3_count2", COUNT, 2);
    check_eq("t3_partial0", PARTIAL, 0);
    check_eq("t3_bp3", BP, 3);
    FLUSH = 1'b1; cyc(); FLUSH = 1'b0;
    check_eq("t3_flush_noop", COUNT, 2);
    word_rd();
    check_eq("t3_od2", OD, 32'hCCDDEE00);
    word_rd();
    check_eq("t3_empty", FIFOEMPTY, 1);

    // 4: unpack
    DIR = 1'b0;
    word_wr(32'hDEADBEEF); word_wr(32'h01020304);
    check_eq("t4_count", COUNT, 2);
    begin
      logic [7:0] exp_b [8];
      exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
      for (int i = 0; i < 8; i++) begin
        check_eq("t4_sdout", SD_OUT, exp_b[i]);
        byte_rd();
      end
    end
    check_eq("t4_empty", FIFOEMPTY, 1);
    check_eq("t4_err0", ERR, 0);
    byte_rd();
    check_eq("t4_err1", ERR, 1);
    check_eq("t4_bp", BP, 3);
    err_clr();
    word_rd();
    check_eq("t4_inactive_rd", ERR, 0);

    // 5: simultaneous push/pop at full, then at empty
    for (int k = 0; k < 8; k++) word_wr({8'(k), 8'hB1, 8'hB2, 8'hB3});
    check_eq("t5_full", FIFOFULL, 1);
    check_eq("t5_sd0", SD_OUT, 8'h00); byte_rd();
    check_eq("t5_sd1", SD_OUT, 8'hB1); byte_rd();
    check_eq("t5_sd2", SD_OUT, 8'hB2); byte_rd();
    check_eq("t5_sd3", SD_OUT, 8'hB3);
    ID = 32'hC0C1C2C3; WORD_WR = 1'b1; BYTE_RD = 1'b1; cyc();
    WORD_WR = 1'b0; BYTE_RD = 1'b0;
    check_eq("t5_count", COUNT, 8);
    check_eq("t5_err", ERR, 0);
    for (int k = 1; k < 9; k++) begin
      exp_w = (k == 8) ? 32'hC0C1C2C3 : {8'(k), 8'hB1, 8'hB2, 8'hB3};
      check_eq("t5_order", OD, exp_w);
      for (int j = 0; j < 4; j++) byte_rd();
    end
    check_eq("t5_empty", FIFOEMPTY, 1);
    ID = 32'h5A5B5C5D; WORD_WR = 1'b1; BYTE_RD = 1'b1; cyc();
    WORD_WR = 1'b0; BYTE_RD = 1'b0;
    check_eq("t5_e_count", COUNT, 1);
    check_eq("t5_e_err", ERR, 1);
    check_eq("t5_e_od", OD, 32'h5A5B5C5D);
    err_clr();
    for (int j = 0; j < 4; j++) byte_rd();
    check_eq("t5_e_empty", FIFOEMPTY, 1);

    // 6: asynchronous reset mid-cycle discards everything
    DIR = 1'b1;
    byte_wr(8'hF1); byte_wr(8'hF2); byte_wr(8'hF3); byte_wr(8'hF4);
    byte_wr(8'h01); byte_wr(8'h02);
    check_eq("t6_pre_count", COUNT, 1);
    check_eq("t6_pre_partial", PARTIAL, 1);
    #2 RST_FIFO_ = 1'b0;
    #1;
    check_eq("t6_rst_count", COUNT, 0);
    check_eq("t6_rst_bp", BP, 3);
    check_eq("t6_rst_empty", FIFOEMPTY, 1);
    check_eq("t6_rst_partial", PARTIAL, 0);
    #1 RST_FIFO_ = 1'b1;
    cyc();
    byte_wr(8'h61); byte_wr(8'h62); byte_wr(8'h63); byte_wr(8'h64);
    check_eq("t6_count", COUNT, 1);
    check_eq("t6_od", OD, 32'h61626364);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
